registrador_mux8x3: RTL and testbench
=====================================

Name: registrador_mux8x3

Overview:
- Eight-entry register bank with one shared address.
- Built from eight enable-gated registers (the registrador function) and one 8:1 selector (the mux8x3 function).
- A single 3-bit key selects both the write target and the read source.
- Serves as the processor's general-purpose register storage (R0–R7). The datapath drives the write data, and the read output feeds the bus/ALU.

Parameters:
- WIDTH, 16, data width of each register, of the write input and of the read output.

Ports:
- clock  input  1  system clock; all register updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all eight registers.
- in  input  WIDTH  write data, common to all registers.
- key  input  3  register index 0–7; selects the write target and the read source.
- w  input  1  write strobe; active-high.
- out  output  WIDTH  contents of register[key], combinational.

Behaviour:
- Storage: eight registers R0..R7, each WIDTH bits.
- Reset:
  - reset=1 forces R0..R7 to 0 immediately, without waiting for a clock edge.
  - Reset has priority over any write.
  - While reset is high, out=0 for every key.
  - On deassertion, registers hold 0 until the first qualifying write.
- Write decode (combinational):
  - Enable e[i] = w AND (key==i).
  - At most one enable is active at a time.
  - With w=0, all enables are 0.
- Register update:
  - On a rising clock edge with reset=0: if e[i]=1 then Ri <= in; otherwise Ri holds.
  - Exactly one register changes per write. The other seven are untouched.
- Read path:
  - out = R[key], purely combinational with zero clock latency.
  - Changing key changes out within the same cycle, without a clock edge.
- Read-during-write:
  - While w=1 before the edge, out shows the old R[key].
  - After the edge, out shows the new value, equal to in.
  - No write-through bypass.
- Write latency: 1 cycle. Data is visible on out right after the capturing edge when key is unchanged.
- Writes are independent of data value. Full WIDTH bits are stored with no truncation or sign handling.
- Reset mid-operation: an asserted reset overrides a simultaneous w=1 edge, and the register stays 0.
- w or key changing between edges has no effect. Only values sampled at the rising edge matter.
- No internal state other than R0..R7. No X propagation from unwritten registers, because reset defines them.

Test Plan:
- Reset: pulse reset asynchronously mid-cycle -> out=0 immediately for key=0..7, with no clock edge needed.
- Write all: for i=0..7, key=i, in=16'h1000+i, w=1, one edge each; then w=0 and sweep key 0..7 -> out=16'h1000+i each, combinationally, with no edges.
- Write-disable: key=3, in=16'hFFFF, w=0, several edges -> R3 keeps 16'h1003 and no other register changes.
- Read-during-write: key=5 holding 16'h1005, in=16'hABCD, w=1 -> out=16'h1005 before the edge and 16'hABCD after it; R4 and R6 are unchanged.
- Reset priority: reset=1 and w=1, key=2, in=16'h5555 across an edge -> R2=0; after release, all eight registers read 0.
- Isolation: write 16'h0000 to R7 and 16'hFFFF to R0 -> R1..R6 retain their previous values; out tracks key changes within the same cycle.

Source files
------------

// File: rtl/registrador_mux8x3.sv
// Eight-entry general-purpose register bank (R0..R7) with one shared 3-bit key
// selecting both the write target and the combinational read source.
module registrador_mux8x3 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       key,
  input  logic             w,
  output logic [WIDTH-1:0] out
);

  logic [7:0]       enable;
  logic [WIDTH-1:0] bank [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
      logic [WIDTH-1:0] data_reg;

      // One-hot write decode: only the register addressed by key is enabled.
      assign enable[gi] = w && (key == 3'(gi));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          data_reg <= '0;
        end else if (enable[gi]) begin
          data_reg <= in;
        end
      end

      assign bank[gi] = data_reg;
    end
  endgenerate

  // Read is purely combinational and shows the stored value (no write-through).
  assign out = bank[key];

endmodule

// File: tb/tb_registrador_mux8x3.sv
// Self-checking bench for registrador_mux8x3: directed scenarios plus random
// traffic checked against an array model of R0..R7.
`timescale 1ns/100ps
module tb_registrador_mux8x3;

  localparam int WIDTH = 16;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic [2:0]       key;
  logic             w;
  logic [WIDTH-1:0] out;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model [8];

  registrador_mux8x3 #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .in(in),
    .key(key),
    .w(w),
    .out(out)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  // One write transaction: drive at the falling edge, capture on the rising edge.
  task automatic do_write(input logic [2:0] k, input logic [WIDTH-1:0] d);
    @(negedge clock);
    key = k;
    in  = d;
    w   = 1'b1;
    @(posedge clock);
    if (!reset) model[k] = d;
    #1;
    w = 1'b0;
    $display("write key=%0d data=%h", k, d);
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 key = 3'(k);
      #0.5;
      checks++;
      if (out !== '0) begin
        errors++;
        $display("FAIL reset_async key=%0d out=%h expected=%h", k, out, 16'h0);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    clear_model();
    for (int k = 0; k < 8; k++) begin
      #1 key = 3'(k);
      #0.5;
      checks++;
      if (out !== '0) begin
        errors++;
        $display("FAIL reset_release key=%0d out=%h expected=%h", k, out, 16'h0);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_all();
    for (int i = 0; i < 8; i++) do_write(3'(i), 16'h1000 + 16'(i));
    for (int k = 0; k < 8; k++) begin
      #1 key = 3'(k);
      #0.5;
      checks++;
      if (out !== 16'h1000 + 16'(k)) begin
        errors++;
        $display("FAIL write_all key=%0d out=%h expected=%h", k, out, 16'h1000 + 16'(k));
      end
    end
    $display("test_write_all done");
  endtask

  task automatic test_write_disable();
    @(negedge clock);
    key = 3'd3;
    in  = 16'hFFFF;
    w   = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      #1 key = 3'(k);
      #0.5;
      checks++;
      if (out !== model[k]) begin
        errors++;
        $display("FAIL write_disable key=%0d out=%h expected=%h", k, out, model[k]);
      end
    end
    $display("test_write_disable done");
  endtask

  task automatic test_read_during_write();
    @(negedge clock);
    key = 3'd5;
    in  = 16'hABCD;
    w   = 1'b1;
    #1;
    checks++;
    if (out !== 16'h1005) begin
      errors++;
      $display("FAIL rdw_before out=%h expected=%h", out, 16'h1005);
    end
    @(posedge clock);
    model[5] = 16'hABCD;
    #1;
    w = 1'b0;
    checks++;
    if (out !== 16'hABCD) begin
      errors++;
      $display("FAIL rdw_after out=%h expected=%h", out, 16'hABCD);
    end
    key = 3'd4;
    #0.5;
    checks++;
    if (out !== 16'h1004) begin
      errors++;
      $display("FAIL rdw_neighbor4 out=%h expected=%h", out, 16'h1004);
    end
    key = 3'd6;
    #0.5;
    checks++;
    if (out !== 16'h1006) begin
      errors++;
      $display("FAIL rdw_neighbor6 out=%h expected=%h", out, 16'h1006);
    end
    $display("test_read_during_write done");
  endtask

  task automatic test_reset_priority();
    @(negedge clock);
    key = 3'd2;
    in  = 16'h5555;
    w   = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out !== '0) begin
      errors++;
      $display("FAIL rst_prio_async out=%h expected=%h", out, 16'h0);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out !== '0) begin
      errors++;
      $display("FAIL rst_prio_edge out=%h expected=%h", out, 16'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    w     = 1'b0;
    clear_model();
    for (int k = 0; k < 8; k++) begin
      #1 key = 3'(k);
      #0.5;
      checks++;
      if (out !== '0) begin
        errors++;
        $display("FAIL rst_prio_release key=%0d out=%h expected=%h", k, out, 16'h0);
      end
    end
    $display("test_reset_priority done");
  endtask

  task automatic test_isolation();
    for (int i = 0; i < 8; i++) do_write(3'(i), 16'($urandom));
    do_write(3'd7, 16'h0000);
    do_write(3'd0, 16'hFFFF);
    @(negedge clock);
    for (int k = 7; k >= 0; k--) begin
      #1 key = 3'(k);
      #0.5;
      checks++;
      if (out !== model[k]) begin
        errors++;
        $display("FAIL isolation key=%0d out=%h expected=%h", k, out, model[k]);
      end
    end
    $display("test_isolation done");
  endtask

  task automatic test_random();
    logic [2:0]       rk;
    logic [WIDTH-1:0] rd;
    logic             rw;
    logic             rr;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      rk = 3'($urandom_range(0, 7));
      rd = 16'($urandom);
      rw = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 31) == 0);
      key = rk;
      in  = rd;
      w   = rw;
      #1;
      checks++;
      if (out !== model[rk]) begin
        errors++;
        $display("FAIL random_pre n=%0d key=%0d out=%h expected=%h", n, rk, out, model[rk]);
      end
      if (rr) begin
        reset = 1'b1;
        clear_model();
        #1;
      end
      @(posedge clock);
      if (!rr && rw) model[rk] = rd;
      #1;
      checks++;
      if (out !== model[rk]) begin
        errors++;
        $display("FAIL random_post n=%0d key=%0d w=%0d rst=%0d out=%h expected=%h",
                 n, rk, rw, rr, out, model[rk]);
      end
      $display("random n=%0d key=%0d w=%0d rst=%0d in=%h out=%h", n, rk, rw, rr, rd, out);
      reset = 1'b0;
    end
    w = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b0;
    in    = '0;
    key   = '0;
    w     = 1'b0;
    clear_model();
    test_reset();
    test_write_all();
    test_write_disable();
    test_read_during_write();
    test_reset_priority();
    test_isolation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
